// File: rtl/rc4_pkg.sv
// Shared key-search definitions: key width, default key ceiling and the
// batch sequencer state encoding.
package rc4_pkg;

  localparam int KEY_W = 24;
  localparam logic [KEY_W-1:0] KEY_MAX_DEFAULT = 24'h3FFFFF;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_OFFER     = 3'd1,
    SEQ_ACKED     = 3'd2,
    SEQ_EXHAUSTED = 3'd3,
    SEQ_HALTED    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/key_batch_sequencer.sv
// Hands out consecutive batches of CORES keys to parallel decrypt cores
// with a level-based offer/acknowledge handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start
// OFFER     | batch at pending_base offered (key_available high)
// ACKED     | batch accepted, waiting for key_read to drop
// EXHAUSTED | final batch accepted, nothing more to offer
// HALTED    | consumer found the message, outputs frozen
module key_batch_sequencer
  import rc4_pkg::*;
#(
  parameter int               CORES     = 4,
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_MAX   = KEY_MAX_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             key_read,
  output logic             key_available,
  output logic [KEY_W-1:0] secret_key,
  output logic [CORES-1:0] batch_mask,
  output logic             out_of_keys,
  output logic             busy
);

  // One extra bit so the batch end past 24'hFFFFFF cannot wrap to 0.
  localparam int PB_W = KEY_W + 1;
  localparam logic [PB_W-1:0] KEY_MAX_EXT = {1'b0, KEY_MAX};

  seq_state_t       state, state_next;
  logic [PB_W-1:0]  pending_base;
  logic [CORES-1:0] mask_next;
  logic             accept;
  logic             load_start;
  logic             final_batch;

  assign final_batch   = (pending_base + PB_W'(CORES - 1)) >= KEY_MAX_EXT;
  assign key_available = (state == SEQ_OFFER);
  assign busy          = (state == SEQ_OFFER) || (state == SEQ_ACKED);

  always_comb begin
    mask_next = '0;
    for (int i = 0; i < CORES; i++) begin
      mask_next[i] = (pending_base + PB_W'(i)) <= KEY_MAX_EXT;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_start = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (start) begin
          state_next = SEQ_OFFER;
          load_start = 1'b1;
        end
      end
      SEQ_OFFER: begin
        if (stop) begin
          state_next = SEQ_HALTED;
        end else if (key_read) begin
          accept     = 1'b1;
          state_next = final_batch ? SEQ_EXHAUSTED : SEQ_ACKED;
        end
      end
      SEQ_ACKED: begin
        if (stop) state_next = SEQ_HALTED;
        else if (!key_read) state_next = SEQ_OFFER;
      end
      SEQ_EXHAUSTED: begin
        if (stop) begin
          state_next = SEQ_HALTED;
        end else if (start) begin
          state_next = SEQ_OFFER;
          load_start = 1'b1;
        end
      end
      SEQ_HALTED: begin
        if (start) begin
          state_next = SEQ_OFFER;
          load_start = 1'b1;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= SEQ_IDLE;
      pending_base <= {1'b0, KEY_START};
      secret_key   <= '0;
      batch_mask   <= '0;
      out_of_keys  <= 1'b0;
    end else begin
      state <= state_next;
      if (load_start) begin
        pending_base <= {1'b0, KEY_START};
        out_of_keys  <= 1'b0;
      end else if (accept) begin
        secret_key   <= pending_base[KEY_W-1:0];
        batch_mask   <= mask_next;
        pending_base <= pending_base + PB_W'(CORES);
        out_of_keys  <= final_batch;
      end
    end
  end

endmodule

// File: doc/key_batch_sequencer.md
KEY_BATCH_SEQUENCER -- requirements
Module: key_batch_sequencer

Interface
REQ-001 Parameter CORES, default 4, number of parallel decrypt cores fed per key batch (power of two, 1..16).
REQ-002 Parameter KEY_START, default 24'h000000, first key of the search.
REQ-003 Parameter KEY_MAX, default 24'h3FFFFF, last legal key (inclusive).
REQ-004 Port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  single-cycle request to begin (or restart) the key search from KEY_START.
REQ-007 Port stop  input  1  consumer found a valid message; freeze the search.
REQ-008 Port key_read  input  1  consumer acknowledge of the offered batch.
REQ-009 Port key_available  output  1  a new batch is offered.
REQ-010 Port secret_key  output  24  base key of the most recently accepted batch; core i uses secret_key+i.
REQ-011 Port batch_mask  output  CORES  bit i set when secret_key+i <= KEY_MAX for the accepted batch.
REQ-012 Port out_of_keys  output  1  the accepted batch is the final one.
REQ-013 Port busy  output  1  high in OFFER and ACKED.

Function
REQ-014 FSM states: IDLE, OFFER, ACKED, EXHAUSTED, HALTED; key_available SHALL be high only in OFFER.
REQ-015 IDLE: start -> OFFER, pending_base <= KEY_START; other inputs ignored.
REQ-016 Accept = OFFER & key_read & !stop; on accept edge secret_key <= pending_base, batch_mask computed from pending_base, pending_base <= pending_base+CORES (25-bit sum, no wrap).
REQ-017 Accept of a non-final batch -> ACKED; ACKED stays while key_read high, -> OFFER on first cycle key_read low (one accept per key_read high level).
REQ-018 Final batch (pending_base+CORES-1 >= KEY_MAX): accept -> EXHAUSTED, out_of_keys <= 1 on the same edge, key_available 0 thereafter.
REQ-019 Partial final batch: batch_mask bits for keys > KEY_MAX SHALL be 0.
REQ-020 stop in OFFER, ACKED or EXHAUSTED -> HALTED; stop wins over simultaneous key_read (no accept); secret_key, batch_mask frozen.
REQ-021 start in EXHAUSTED or HALTED -> OFFER, pending_base <= KEY_START, out_of_keys <= 0; start in OFFER/ACKED ignored.
REQ-022 secret_key and batch_mask SHALL change only on an accept edge or reset.
REQ-023 Latency: key_available rises one cycle after start, and one cycle after key_read falls in ACKED.

Reset
REQ-024 reset asynchronously forces IDLE, key_available 0, secret_key 0, batch_mask 0, out_of_keys 0, busy 0, pending_base KEY_START, in any state, including mid-handshake.
REQ-025 First action after reset release requires start; no batch is offered spontaneously.

Structure
REQ-026 Shared package rc4_pkg holds KEY_W=24, default KEY_MAX, and the sequencer state enum.
REQ-027 Single module, no sub-modules; batch_mask is a combinational compare loop registered at accept.

Verification
REQ-030 KEY_MAX=10, CORES=4: start, 1-cycle key_read per offer -> secret_key 0,4,8; masks 1111,1111,0111; out_of_keys high at third accept; key_available then stays 0.
REQ-031 key_read held high 5 cycles in OFFER -> exactly one accept, secret_key advances by 4 only once, ACKED until key_read low.
REQ-032 stop and key_read together in OFFER with pending_base 8 -> HALTED, secret_key keeps 4, key_available 0 next cycle.
REQ-033 reset asserted mid-cycle in ACKED -> all outputs 0 before next clock edge, IDLE after release; key_available stays 0 without start.
REQ-034 Start in EXHAUSTED -> out_of_keys 0, key_available 1 next cycle, next accept gives secret_key 0.
REQ-035 Defaults: run to pending_base 24'h3FFFFC -> accept gives mask 1111, out_of_keys 1, no 24-bit wrap to 0.
